// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs decoded RV32I fields back into a 32-bit instruction word. This is the
// inverse of the immediate generator: the immediate is taken in the same form
// the generator produces. A word that goes back through the generator therefore
// yields the original i_Imm.
//
// Requests arrive on a valid/ready handshake. Encoded words go into a 2-entry
// in-order output buffer, which drives a second valid/ready handshake.
//
// An accepted request that cannot be encoded is dropped. A request cannot be
// encoded when its opcode is unsupported or its immediate is out of range.
// A dropped request completes its handshake but writes nothing to the buffer.
// It sets the sticky o_Error flag and bumps o_ErrCount.
//
// Ports:
//   i_Clk          clock, all state updates on the rising edge
//   i_Reset        synchronous active-high reset
//   i_Valid        upstream request valid
//   o_Ready        encoder can accept a request (buffer not full)
//   i_Opcode       7-bit opcode (R, I, I-load, S, B, LUI, AUIPC)
//   i_Rd           destination register index
//   i_Rs1, i_Rs2   source register indices
//   i_Funct3       funct3 field
//   i_Funct7       funct7 field (R-type only)
//   i_Imm          immediate, in immediate-generator output format
//   o_Valid        o_Instruction holds a buffered word
//   i_Ready        downstream accepts o_Instruction
//   o_Instruction  head of the output buffer
//   o_Error        sticky: an unencodable request was dropped
//   o_InstrCount   words emitted (o_Valid & i_Ready), wraps
//   o_ErrCount     requests dropped, wraps
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [6:0]       i_Opcode,
  input  logic [4:0]       i_Rd,
  input  logic [4:0]       i_Rs1,
  input  logic [4:0]       i_Rs2,
  input  logic [2:0]       i_Funct3,
  input  logic [6:0]       i_Funct7,
  input  logic [31:0]      i_Imm,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [31:0]      o_Instruction,
  output logic             o_Error,
  output logic [CNT_W-1:0] o_InstrCount,
  output logic [CNT_W-1:0] o_ErrCount
);

  localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
  localparam logic [6:0] OP_I_L_TYPE = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_ok;
  logic        fits_12;   // i_Imm is a sign-extended 12-bit value
  logic        fits_20;   // i_Imm is a sign-extended 20-bit value
  logic [11:0] b;         // branch offset in the generator's offset[12:1] form

  // A value fits when every bit above the field matches the field's top bit.
  // That is the same as saying all of those bits are equal.
  assign fits_12 = (&i_Imm[31:11]) | ~(|i_Imm[31:11]);
  assign fits_20 = (&i_Imm[31:19]) | ~(|i_Imm[31:19]);
  assign b       = i_Imm[11:0];

  // NOTE: every output of a combinational block gets a default first, so that
  // paths the case does not cover still assign it and no latch is inferred.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (i_Opcode)
      OP_R_TYPE: begin
        enc_word = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_Opcode};
        enc_ok   = 1'b1;
      end
      OP_I_TYPE, OP_I_L_TYPE: begin
        enc_word = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, i_Opcode};
        enc_ok   = fits_12;
      end
      OP_S_TYPE: begin
        enc_word = {i_Imm[11:5], i_Rs2, i_Rs1, i_Funct3, i_Imm[4:0], i_Opcode};
        enc_ok   = fits_12;
      end
      OP_B_TYPE: begin
        enc_word = {b[11], b[9:4], i_Rs2, i_Rs1, i_Funct3, b[3:0], b[10], i_Opcode};
        enc_ok   = fits_12;
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {i_Imm[19:0], i_Rd, i_Opcode};
        enc_ok   = fits_20;
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry output buffer
  //
  // head_q is the word on o_Instruction and tail_q is the word queued behind it.
  // head_q changes only when a new word takes its place. After the last pop it
  // therefore keeps showing the last word.
  // ---------------------------------------------------------------------------
  logic [1:0]  count_q;
  logic [31:0] head_q;
  logic [31:0] tail_q;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop;

  // Ready and valid come only from registered occupancy. i_Ready therefore has
  // no combinational path to o_Ready.
  assign o_Ready       = (count_q != 2'd2);
  assign o_Valid       = (count_q != 2'd0);
  assign o_Instruction = head_q;

  assign accept = i_Valid & o_Ready;
  assign push   = accept & enc_ok;
  assign drop   = accept & ~enc_ok;
  assign pop    = o_Valid & i_Ready;

  // NOTE: sequential state uses non-blocking assignments only. Then every flop
  // in this block samples the values from before the edge, whatever the
  // statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count_q      <= 2'd0;
      head_q       <= '0;
      o_Error      <= 1'b0;
      o_InstrCount <= '0;
      o_ErrCount   <= '0;
    end else begin
      case ({push, pop})
        // Push and pop together can only happen with one entry held. The full
        // case has o_Ready low, and the empty case has nothing to pop. The new
        // word replaces the departing head.
        2'b11: head_q <= enc_word;
        2'b10: begin
          if (count_q == 2'd0) head_q <= enc_word;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        default: ;
      endcase

      if (drop) begin
        o_Error    <= 1'b1;
        o_ErrCount <= o_ErrCount + 1'b1;
      end

      if (pop) o_InstrCount <= o_InstrCount + 1'b1;
    end
  end

  // NOTE: the tail slot is storage only and has no reset. Its contents are
  // never observed until count_q says it was written, and count_q is reset.
  always_ff @(posedge i_Clk) begin
    if (push && !pop && count_q == 2'd1) tail_q <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A behavioural model tracks the same
// state as the DUT: a queue of pending words, the sticky error flag and both
// counters. The model encodes each word from the field-placement rules with
// shifts and masks. It range-checks immediates as signed integers. The
// immediate generator's decode is modelled to check round trips.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Valid = 1'b0;
  logic        o_Ready;
  logic [6:0]  i_Opcode = '0;
  logic [4:0]  i_Rd = '0;
  logic [4:0]  i_Rs1 = '0;
  logic [4:0]  i_Rs2 = '0;
  logic [2:0]  i_Funct3 = '0;
  logic [6:0]  i_Funct7 = '0;
  logic [31:0] i_Imm = '0;
  logic        o_Valid;
  logic        i_Ready = 1'b0;
  logic [31:0] o_Instruction;
  logic        o_Error;
  logic [15:0] o_InstrCount;
  logic [15:0] o_ErrCount;

  instr_encoder #(.CNT_W(16)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Opcode(i_Opcode), .i_Rd(i_Rd), .i_Rs1(i_Rs1), .i_Rs2(i_Rs2),
    .i_Funct3(i_Funct3), .i_Funct7(i_Funct7), .i_Imm(i_Imm),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Instruction(o_Instruction),
    .o_Error(o_Error), .o_InstrCount(o_InstrCount), .o_ErrCount(o_ErrCount)
  );

  always #5 i_Clk = ~i_Clk;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_IL  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  typedef struct {
    logic [31:0] word;
    logic [31:0] imm;
    logic [6:0]  op;
  } entry_t;

  entry_t      exp_q[$];
  logic        m_err = 1'b0;
  logic [15:0] m_icnt = '0;
  logic [15:0] m_ecnt = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm, output logic [31:0] w);
    int s;
    logic [31:0] bb;
    logic [31:0] base_rs;
    s = imm;
    bb = imm & 32'hFFF;
    base_rs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w = '0;
    case (op)
      OP_R: begin
        w = (32'(f7) << 25) | base_rs | (32'(rd) << 7);
        return 1'b1;
      end
      OP_I, OP_IL: begin
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        return (s >= -2048) && (s <= 2047);
      end
      OP_S: begin
        w = (((imm >> 5) & 32'h7F) << 25) | base_rs | ((imm & 32'h1F) << 7);
        return (s >= -2048) && (s <= 2047);
      end
      OP_B: begin
        w = (((bb >> 11) & 32'h1) << 31) | (((bb >> 4) & 32'h3F) << 25) | base_rs
          | ((bb & 32'hF) << 8) | (((bb >> 10) & 32'h1) << 7);
        return (s >= -2048) && (s <= 2047);
      end
      OP_LUI, OP_AUI: begin
        w = ((imm & 32'hFFFFF) << 12) | (32'(rd) << 7) | 32'(op);
        return (s >= -524288) && (s <= 524287);
      end
      default: return 1'b0;
    endcase
  endfunction

  // Immediate generator: recovers the immediate from an encoded word.
  function automatic logic [31:0] imm_gen(input logic [31:0] w);
    logic [31:0] r;
    case (w[6:0])
      OP_I, OP_IL:    r = {{20{w[31]}}, w[31:20]};
      OP_S:           r = {{20{w[31]}}, w[31:25], w[11:7]};
      OP_B:           r = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
      OP_LUI, OP_AUI: r = {{12{w[31]}}, w[31:12]};
      default:        r = '0;
    endcase
    return r;
  endfunction

  // Advance the model by one rising edge, using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] w;
    bit ok;
    bit acc;
    entry_t e;
    if (i_Reset) begin
      exp_q.delete();
      m_err = 1'b0;
      m_icnt = '0;
      m_ecnt = '0;
    end else begin
      acc = i_Valid && (exp_q.size() < 2);
      ok = ref_encode(i_Opcode, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Imm, w);
      if (exp_q.size() != 0 && i_Ready) begin
        void'(exp_q.pop_front());
        m_icnt = m_icnt + 16'd1;
      end
      if (acc) begin
        if (ok) begin
          e.word = w; e.imm = i_Imm; e.op = i_Opcode;
          exp_q.push_back(e);
        end else begin
          m_err = 1'b1;
          m_ecnt = m_ecnt + 16'd1;
        end
      end
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    model_edge();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    i_Valid = 1'b1; i_Opcode = op; i_Rd = rd; i_Rs1 = rs1; i_Rs2 = rs2;
    i_Funct3 = f3; i_Funct7 = f7; i_Imm = imm;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    i_Reset = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0;
    tick(); tick();
    i_Reset = 1'b0;
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_Ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", o_Ready); else pass_cnt++;
    total_cnt++; if (o_Instruction !== 32'h0) $display("FAIL reset_instr got %08h exp 00000000", o_Instruction); else pass_cnt++;
    total_cnt++; if (o_Error !== 1'b0) $display("FAIL reset_error got %0b exp 0", o_Error); else pass_cnt++;
    total_cnt++; if (o_InstrCount !== 16'd0) $display("FAIL reset_icnt got %0d exp 0", o_InstrCount); else pass_cnt++;
    total_cnt++; if (o_ErrCount !== 16'd0) $display("FAIL reset_ecnt got %0d exp 0", o_ErrCount); else pass_cnt++;
  endtask

  task automatic test_addi();
    i_Ready = 1'b1;
    set_req(OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    tick();
    i_Valid = 1'b0;
    total_cnt++; if (o_Valid !== 1'b1) $display("FAIL addi_valid got %0b exp 1", o_Valid); else pass_cnt++;
    total_cnt++; if (o_Instruction !== 32'hFFF10093) $display("FAIL addi_word got %08h exp FFF10093", o_Instruction); else pass_cnt++;
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL addi_drain got %0b exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_InstrCount !== 16'd1) $display("FAIL addi_icnt got %0d exp 1", o_InstrCount); else pass_cnt++;
  endtask

  task automatic test_sw_lui();
    i_Ready = 1'b0;
    set_req(OP_S, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'h00000008);
    tick();
    set_req(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00012345);
    tick();
    i_Valid = 1'b0;
    total_cnt++; if (o_Instruction !== 32'h00312423) $display("FAIL sw_word got %08h exp 00312423", o_Instruction); else pass_cnt++;
    total_cnt++; if (o_Ready !== 1'b0) $display("FAIL sw_lui_full got %0b exp 0", o_Ready); else pass_cnt++;
    i_Ready = 1'b1;
    tick();
    total_cnt++; if (o_Instruction !== 32'h123452B7) $display("FAIL lui_word got %08h exp 123452B7", o_Instruction); else pass_cnt++;
    total_cnt++; if (o_Valid !== 1'b1) $display("FAIL lui_valid got %0b exp 1", o_Valid); else pass_cnt++;
    tick();
    total_cnt++; if (o_InstrCount !== 16'd3) $display("FAIL sw_lui_icnt got %0d exp 3", o_InstrCount); else pass_cnt++;
  endtask

  task automatic test_beq_roundtrip();
    i_Ready = 1'b0;
    set_req(OP_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE);
    tick();
    i_Valid = 1'b0;
    total_cnt++; if (o_Instruction !== 32'hFE000EE3) $display("FAIL beq_word got %08h exp FE000EE3", o_Instruction); else pass_cnt++;
    total_cnt++; if (imm_gen(o_Instruction) !== 32'hFFFFFFFE) $display("FAIL beq_roundtrip got %08h exp FFFFFFFE", imm_gen(o_Instruction)); else pass_cnt++;
    i_Ready = 1'b1;
    tick();
  endtask

  task automatic test_errors();
    i_Ready = 1'b1;
    set_req(OP_I, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h00000800);
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL err_range_valid got %0b exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_Error !== 1'b1) $display("FAIL err_range_flag got %0b exp 1", o_Error); else pass_cnt++;
    set_req(7'b1111111, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0);
    tick();
    i_Valid = 1'b0;
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL err_op_valid got %0b exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_ErrCount !== 16'd2) $display("FAIL err_ecnt got %0d exp 2", o_ErrCount); else pass_cnt++;
    total_cnt++; if (o_InstrCount !== 16'd4) $display("FAIL err_icnt got %0d exp 4", o_InstrCount); else pass_cnt++;
    total_cnt++; if (o_Error !== 1'b1) $display("FAIL err_sticky got %0b exp 1", o_Error); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [15:0] icnt0;
    icnt0 = o_InstrCount;
    for (int k = 0; k < 3; k++)
      void'(ref_encode(OP_I, 5'(10 + k), 5'd3, 5'd0, 3'd0, 7'd0, 32'(k + 1), w[k]));
    i_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(OP_I, 5'(10 + k), 5'd3, 5'd0, 3'd0, 7'd0, 32'(k + 1));
      tick();
      total_cnt++; if (o_Instruction !== w[0]) $display("FAIL bp_hold_%0d got %08h exp %08h", k, o_Instruction, w[0]); else pass_cnt++;
      total_cnt++; if (o_Ready !== (k == 0)) $display("FAIL bp_ready_%0d got %0b exp %0b", k, o_Ready, k == 0); else pass_cnt++;
    end
    // The third request is still presented and enters as the head drains.
    i_Ready = 1'b1;
    tick();
    total_cnt++; if (o_Instruction !== w[1]) $display("FAIL bp_out1 got %08h exp %08h", o_Instruction, w[1]); else pass_cnt++;
    tick();
    i_Valid = 1'b0;
    total_cnt++; if (o_Instruction !== w[2]) $display("FAIL bp_out2 got %08h exp %08h", o_Instruction, w[2]); else pass_cnt++;
    tick();
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL bp_empty got %0b exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_InstrCount !== icnt0 + 16'd3) $display("FAIL bp_icnt got %0d exp %0d", o_InstrCount, icnt0 + 16'd3); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    i_Ready = 1'b0;
    set_req(OP_R, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0);
    tick();
    set_req(OP_AUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    tick();
    i_Valid = 1'b0;
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    total_cnt++; if (o_Valid !== 1'b0) $display("FAIL rmid_valid got %0b exp 0", o_Valid); else pass_cnt++;
    total_cnt++; if (o_Ready !== 1'b1) $display("FAIL rmid_ready got %0b exp 1", o_Ready); else pass_cnt++;
    total_cnt++; if (o_Error !== 1'b0) $display("FAIL rmid_error got %0b exp 0", o_Error); else pass_cnt++;
    total_cnt++; if (o_InstrCount !== 16'd0 || o_ErrCount !== 16'd0)
      $display("FAIL rmid_counts got %0d/%0d exp 0/0", o_InstrCount, o_ErrCount); else pass_cnt++;
    i_Ready = 1'b1;
    set_req(OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    tick();
    i_Valid = 1'b0;
    total_cnt++; if (o_Instruction !== 32'hFFF10093) $display("FAIL rmid_next got %08h exp FFF10093", o_Instruction); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops[8];
    logic [31:0] edges[8];
    logic [31:0] imm;
    ops = '{OP_R, OP_I, OP_IL, OP_S, OP_B, OP_LUI, OP_AUI, 7'b1110011};
    edges = '{32'h000007FF, 32'hFFFFF800, 32'h00000800, 32'hFFFFF7FF,
              32'h0007FFFF, 32'hFFF80000, 32'h00080000, 32'hFFF7FFFF};
    for (int i = 0; i < 600; i++) begin
      total_cnt++; if (o_Valid !== (exp_q.size() != 0)) $display("FAIL rnd_valid c%0d got %0b", i, o_Valid); else pass_cnt++;
      total_cnt++; if (o_Ready !== (exp_q.size() < 2)) $display("FAIL rnd_ready c%0d got %0b", i, o_Ready); else pass_cnt++;
      total_cnt++; if (o_Error !== m_err) $display("FAIL rnd_error c%0d got %0b exp %0b", i, o_Error, m_err); else pass_cnt++;
      total_cnt++; if (o_InstrCount !== m_icnt || o_ErrCount !== m_ecnt)
        $display("FAIL rnd_counts c%0d got %0d/%0d exp %0d/%0d", i, o_InstrCount, o_ErrCount, m_icnt, m_ecnt); else pass_cnt++;
      if (exp_q.size() != 0) begin
        total_cnt++; if (o_Instruction !== exp_q[0].word)
          $display("FAIL rnd_word c%0d got %08h exp %08h", i, o_Instruction, exp_q[0].word); else pass_cnt++;
        if (exp_q[0].op != OP_R) begin
          total_cnt++; if (imm_gen(o_Instruction) !== exp_q[0].imm)
            $display("FAIL rnd_roundtrip c%0d got %08h exp %08h", i, imm_gen(o_Instruction), exp_q[0].imm); else pass_cnt++;
        end
      end
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = {{20{1'b0}}, 12'($urandom)} ^ (($urandom & 1) != 0 ? 32'hFFFFF000 : 32'h0);
        2: imm = {{12{1'b0}}, 20'($urandom)} ^ (($urandom & 1) != 0 ? 32'hFFF00000 : 32'h0);
        default: imm = edges[$urandom_range(0, 7)];
      endcase
      set_req(ops[$urandom_range(0, 7)], 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), imm);
      i_Valid = ($urandom_range(0, 3) != 0);
      i_Ready = ($urandom_range(0, 2) != 0);
      i_Reset = ($urandom_range(0, 149) == 0);
      tick();
      i_Reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sw_lui();
    test_beq_roundtrip();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
